// File: rtl/des_cbc_ctrl.sv
// DES-CBC block controller: one encrypt and one decrypt combinational DES core
// around a registered key/chain, with a ready/valid stream in and out.

module des_core #(
  parameter bit DECRYPT = 1'b0
) (
  input  logic [63:0] key,
  input  logic [63:0] din,
  output logic [63:0] dout
);
  // Tables hold 1-based DES bit positions (1 = MSB), left-aligned, one byte per entry.
  localparam logic [511:0] IP_T = {
    8'd58,8'd50,8'd42,8'd34,8'd26,8'd18,8'd10,8'd2, 8'd60,8'd52,8'd44,8'd36,8'd28,8'd20,8'd12,8'd4,
    8'd62,8'd54,8'd46,8'd38,8'd30,8'd22,8'd14,8'd6, 8'd64,8'd56,8'd48,8'd40,8'd32,8'd24,8'd16,8'd8,
    8'd57,8'd49,8'd41,8'd33,8'd25,8'd17,8'd9,8'd1,  8'd59,8'd51,8'd43,8'd35,8'd27,8'd19,8'd11,8'd3,
    8'd61,8'd53,8'd45,8'd37,8'd29,8'd21,8'd13,8'd5, 8'd63,8'd55,8'd47,8'd39,8'd31,8'd23,8'd15,8'd7};
  localparam logic [511:0] FP_T = {
    8'd40,8'd8,8'd48,8'd16,8'd56,8'd24,8'd64,8'd32, 8'd39,8'd7,8'd47,8'd15,8'd55,8'd23,8'd63,8'd31,
    8'd38,8'd6,8'd46,8'd14,8'd54,8'd22,8'd62,8'd30, 8'd37,8'd5,8'd45,8'd13,8'd53,8'd21,8'd61,8'd29,
    8'd36,8'd4,8'd44,8'd12,8'd52,8'd20,8'd60,8'd28, 8'd35,8'd3,8'd43,8'd11,8'd51,8'd19,8'd59,8'd27,
    8'd34,8'd2,8'd42,8'd10,8'd50,8'd18,8'd58,8'd26, 8'd33,8'd1,8'd41,8'd9,8'd49,8'd17,8'd57,8'd25};
  localparam logic [511:0] E_T = {
    8'd32,8'd1,8'd2,8'd3,8'd4,8'd5,8'd4,8'd5,8'd6,8'd7,8'd8,8'd9,8'd8,8'd9,8'd10,8'd11,
    8'd12,8'd13,8'd12,8'd13,8'd14,8'd15,8'd16,8'd17,8'd16,8'd17,8'd18,8'd19,8'd20,8'd21,8'd20,8'd21,
    8'd22,8'd23,8'd24,8'd25,8'd24,8'd25,8'd26,8'd27,8'd28,8'd29,8'd28,8'd29,8'd30,8'd31,8'd32,8'd1,
    128'd0};
  localparam logic [511:0] P_T = {
    8'd16,8'd7,8'd20,8'd21,8'd29,8'd12,8'd28,8'd17,8'd1,8'd15,8'd23,8'd26,8'd5,8'd18,8'd31,8'd10,
    8'd2,8'd8,8'd24,8'd14,8'd32,8'd27,8'd3,8'd9,8'd19,8'd13,8'd30,8'd6,8'd22,8'd11,8'd4,8'd25,
    256'd0};
  localparam logic [511:0] PC1_T = {
    8'd57,8'd49,8'd41,8'd33,8'd25,8'd17,8'd9,8'd1,8'd58,8'd50,8'd42,8'd34,8'd26,8'd18,
    8'd10,8'd2,8'd59,8'd51,8'd43,8'd35,8'd27,8'd19,8'd11,8'd3,8'd60,8'd52,8'd44,8'd36,
    8'd63,8'd55,8'd47,8'd39,8'd31,8'd23,8'd15,8'd7,8'd62,8'd54,8'd46,8'd38,8'd30,8'd22,
    8'd14,8'd6,8'd61,8'd53,8'd45,8'd37,8'd29,8'd21,8'd13,8'd5,8'd28,8'd20,8'd12,8'd4,
    64'd0};
  localparam logic [511:0] PC2_T = {
    8'd14,8'd17,8'd11,8'd24,8'd1,8'd5,8'd3,8'd28,8'd15,8'd6,8'd21,8'd10,
    8'd23,8'd19,8'd12,8'd4,8'd26,8'd8,8'd16,8'd7,8'd27,8'd20,8'd13,8'd2,
    8'd41,8'd52,8'd31,8'd37,8'd47,8'd55,8'd30,8'd40,8'd51,8'd45,8'd33,8'd48,
    8'd44,8'd49,8'd39,8'd56,8'd34,8'd53,8'd46,8'd42,8'd50,8'd36,8'd29,8'd32,
    128'd0};
  // S-boxes 1..8, each 4 rows x 16 nibbles, row-major, MSB first.
  localparam logic [2047:0] SBOX_T = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};
  // Rounds that rotate the key halves by two instead of one (round 1 = MSB).
  localparam logic [15:0] SH2 = 16'b0011_1111_0111_1110;

  function automatic logic [63:0] permute(input logic [63:0] src, input int src_w,
                                          input logic [511:0] tbl, input int dst_w);
    logic [63:0] res;
    int          idx;
    res = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < dst_w) begin
        idx = int'(tbl[9'(511 - 8 * i) -: 8]);
        res[6'(dst_w - 1 - i)] = src[6'(src_w - idx)];
      end
    end
    return res;
  endfunction

  function automatic logic [31:0] sbox(input logic [47:0] x);
    logic [5:0]  six;
    logic [5:0]  k;
    logic [31:0] y;
    y = '0;
    for (int b = 0; b < 8; b++) begin
      six = x[6'(47 - 6 * b) -: 6];
      k   = {six[5], six[0], six[4:1]};
      y[5'(31 - 4 * b) -: 4] = SBOX_T[11'(2047 - 256 * b - 4 * int'(k)) -: 4];
    end
    return y;
  endfunction

  always_comb begin : rounds
    logic [63:0] t;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [47:0] e;
    logic [31:0] l, r, f;
    t = permute(key, 64, PC1_T, 56);
    c = t[55:28];
    d = t[27:0];
    for (int i = 0; i < 16; i++) begin
      if (SH2[4'(15 - i)]) begin
        c = {c[25:0], c[27:26]};
        d = {d[25:0], d[27:26]};
      end else begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      ks[i] = 48'(permute({8'h00, c, d}, 56, PC2_T, 48));
    end
    t = permute(din, 64, IP_T, 64);
    l = t[63:32];
    r = t[31:0];
    // Decryption is the same network with the subkeys applied in reverse.
    for (int i = 0; i < 16; i++) begin
      e = 48'(permute({32'h0, r}, 32, E_T, 48));
      f = 32'(permute({32'h0, sbox(e ^ ks[4'(DECRYPT ? 15 - i : i)])}, 32, P_T, 32));
      f = f ^ l;
      l = r;
      r = f;
    end
    dout = permute({r, l}, 64, FP_T, 64);
  end
endmodule

module des_cbc_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [63:0]      cfg_key,
  input  logic [63:0]      cfg_iv,
  input  logic             cfg_mode,
  input  logic             in_valid,
  input  logic [63:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [63:0]      out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count
);
  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t           state_q, state_d;
  logic [63:0]      key_q, key_d, chain_q, chain_d, out_data_q, out_data_d;
  logic             mode_q, mode_d, out_last_q, out_last_d, out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] blk_count_q, blk_count_d;
  logic [63:0]      enc_res, dec_res;
  logic             accept;

  des_core #(.DECRYPT(1'b0)) u_enc (.key(key_q), .din(in_data ^ chain_q), .dout(enc_res));
  des_core #(.DECRYPT(1'b1)) u_dec (.key(key_q), .din(in_data), .dout(dec_res));

  // A final block stays unreplaced until consumed; cfg_we in RUN claims the cycle.
  assign in_ready = ((state_q == RUN) & ~cfg_we) |
                    ((state_q == OUT) & out_ready & ~out_last_q);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    mode_d      = mode_q;
    chain_d     = chain_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    blk_count_d = blk_count_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_we) begin
          key_d       = cfg_key;
          mode_d      = cfg_mode;
          chain_d     = cfg_iv;
          blk_count_d = '0;
          state_d     = RUN;
        end
      end
      RUN: ;
      OUT: begin
        if (out_ready & ~accept) begin
          out_valid_d = 1'b0;
          state_d     = out_last_q ? IDLE : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      out_data_d  = mode_q ? (dec_res ^ chain_q) : enc_res;
      chain_d     = mode_q ? in_data : enc_res;
      out_last_d  = in_last;
      out_valid_d = 1'b1;
      state_d     = OUT;
      if (blk_count_q != '1) blk_count_d = blk_count_q + CNT_W'(1);
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      mode_q      <= 1'b0;
      chain_q     <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      blk_count_q <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      mode_q      <= mode_d;
      chain_q     <= chain_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      blk_count_q <= blk_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign blk_count = blk_count_q;
endmodule
